// File: rtl/sequencer_pkg.sv
// Shared types for the LEGv8 stage sequencer: phase encoding and datapath word width.
package sequencer_pkg;

  // Matches the WORD width used by the datapath constants.
  localparam int WORD = 64;

  typedef enum logic [2:0] {
    PH_IDLE      = 3'd0,
    PH_FETCH     = 3'd1,
    PH_DECODE    = 3'd2,
    PH_EXECUTE   = 3'd3,
    PH_MEMORY    = 3'd4,
    PH_WRITEBACK = 3'd5,
    PH_HALTED    = 3'd6
  } phase_t;

endpackage

// File: rtl/stage_sequencer.sv
// Single-clock control FSM that steps the non-pipelined LEGv8 core through its five stages
// and issues one-cycle stage enables in place of the old oscillator/delay-chain phase clocks.
//
// state        | meaning
// PH_IDLE      | waiting for run; halt_req here halts immediately
// PH_FETCH     | instruction memory read
// PH_DECODE    | register file read
// PH_EXECUTE   | ALU cycle, no enables
// PH_MEMORY    | data memory access, waits on mem_ready up to MEM_TIMEOUT cycles
// PH_WRITEBACK | register write and PC update, instruction retires
// PH_HALTED    | stopped; only reset leaves
module stage_sequencer
  import sequencer_pkg::*;
#(
  parameter int MAX_INSTR   = 0,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            mem_access,
  input  logic            mem_ready,
  input  logic            halt_req,
  output logic            pc_we,
  output logic            instr_mem_en,
  output logic            reg_read_en,
  output logic            mem_en,
  output logic            reg_write_en,
  output logic [2:0]      phase,
  output logic            busy,
  output logic            halted,
  output logic            mem_error,
  output logic [WORD-1:0] retired
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WORD-1:0]   MAX_CNT   = WORD'(MAX_INSTR);

  phase_t            state_q;
  phase_t            state_d;
  logic [WAIT_W-1:0] wait_q;
  logic              halt_q;
  logic              mem_error_q;
  logic [WORD-1:0]   retired_q;
  logic              limit_hit;
  logic              mem_stall;
  logic              mem_timeout;
  logic              busy_s;

  assign busy_s      = (state_q != PH_IDLE) && (state_q != PH_HALTED);
  assign mem_stall   = (state_q == PH_MEMORY) && mem_access && !mem_ready;
  assign mem_timeout = mem_stall && (wait_q == WAIT_LAST);
  assign limit_hit   = (MAX_INSTR != 0) && ((retired_q + WORD'(1)) == MAX_CNT);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PH_IDLE: begin
        if (halt_req)  state_d = PH_HALTED;
        else if (run)  state_d = PH_FETCH;
      end
      PH_FETCH:   state_d = PH_DECODE;
      PH_DECODE:  state_d = PH_EXECUTE;
      PH_EXECUTE: state_d = PH_MEMORY;
      PH_MEMORY: begin
        if (!mem_stall)       state_d = PH_WRITEBACK;
        else if (mem_timeout) state_d = PH_HALTED;
      end
      PH_WRITEBACK: begin
        if (halt_q || limit_hit) state_d = PH_HALTED;
        else if (run)            state_d = PH_FETCH;
        else                     state_d = PH_IDLE;
      end
      PH_HALTED: state_d = PH_HALTED;
      default:   state_d = PH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= PH_IDLE;
      wait_q      <= '0;
      halt_q      <= 1'b0;
      mem_error_q <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q <= state_d;
      // Held at zero outside MEMORY so every access starts its wait from zero.
      if (state_q != PH_MEMORY) wait_q <= '0;
      else if (mem_stall)       wait_q <= wait_q + WAIT_W'(1);
      if (halt_req && busy_s)   halt_q <= 1'b1;
      if (mem_timeout)          mem_error_q <= 1'b1;
      if (state_q == PH_WRITEBACK) retired_q <= retired_q + WORD'(1);
    end
  end

  assign instr_mem_en = (state_q == PH_FETCH);
  assign reg_read_en  = (state_q == PH_DECODE);
  assign mem_en       = (state_q == PH_MEMORY) && mem_access;
  assign reg_write_en = (state_q == PH_WRITEBACK);
  assign pc_we        = (state_q == PH_WRITEBACK);
  assign phase        = state_q;
  assign busy         = busy_s;
  assign halted       = (state_q == PH_HALTED);
  assign mem_error    = mem_error_q;
  assign retired      = retired_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: instruction-level reference model expands each
// instruction into its expected per-cycle phase trace and checks every output each cycle.
module tb_stage_sequencer;
  import sequencer_pkg::*;

  localparam int MEM_TIMEOUT = 15;

  logic            clk = 1'b0;
  logic            reset, run, mem_access, mem_ready, halt_req;
  logic            pc_we, instr_mem_en, reg_read_en, mem_en, reg_write_en;
  logic [2:0]      phase;
  logic            busy, halted, mem_error;
  logic [WORD-1:0] retired;

  logic            l_pc_we, l_instr_mem_en, l_reg_read_en, l_mem_en, l_reg_write_en;
  logic [2:0]      l_phase;
  logic            l_busy, l_halted, l_mem_error;
  logic [WORD-1:0] l_retired;

  int              n_total = 0;
  int              n_pass  = 0;
  int              n_fail  = 0;
  logic [63:0]     exp_retired;
  logic            exp_err;
  logic            exp_latch;

  always #5 clk = ~clk;

  stage_sequencer #(.MAX_INSTR(0), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .run(run), .mem_access(mem_access), .mem_ready(mem_ready),
    .halt_req(halt_req), .pc_we(pc_we), .instr_mem_en(instr_mem_en),
    .reg_read_en(reg_read_en), .mem_en(mem_en), .reg_write_en(reg_write_en),
    .phase(phase), .busy(busy), .halted(halted), .mem_error(mem_error), .retired(retired)
  );

  stage_sequencer #(.MAX_INSTR(4), .MEM_TIMEOUT(MEM_TIMEOUT)) dut_lim (
    .clk(clk), .reset(reset), .run(run), .mem_access(mem_access), .mem_ready(mem_ready),
    .halt_req(halt_req), .pc_we(l_pc_we), .instr_mem_en(l_instr_mem_en),
    .reg_read_en(l_reg_read_en), .mem_en(l_mem_en), .reg_write_en(l_reg_write_en),
    .phase(l_phase), .busy(l_busy), .halted(l_halted), .mem_error(l_mem_error),
    .retired(l_retired)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One clock cycle: drive inputs, check the expected phase and all derived outputs, advance.
  task automatic cyc(input int ph, input logic r, input logic a, input logic rdy, input logic h);
    run = r; mem_access = a; mem_ready = rdy; halt_req = h;
    #1;
    chk("phase",        64'(phase),   64'(ph));
    chk("instr_mem_en", instr_mem_en, 64'(ph == 1));
    chk("reg_read_en",  reg_read_en,  64'(ph == 2));
    chk("mem_en",       mem_en,       64'((ph == 4) && a));
    chk("reg_write_en", reg_write_en, 64'(ph == 5));
    chk("pc_we",        pc_we,        64'(ph == 5));
    chk("busy",         busy,         64'(ph >= 1 && ph <= 5));
    chk("halted",       halted,       64'(ph == 6));
    chk("mem_error",    mem_error,    64'(exp_err));
    chk("retired",      retired,      exp_retired);
    if (h && ph >= 1 && ph <= 5) exp_latch = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b1; mem_access = 1'b1; mem_ready = 1'b0; halt_req = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_retired = '0; exp_err = 1'b0; exp_latch = 1'b0;
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic run_at(input int s, input int drop_at);
    return logic'(s < drop_at);
  endfunction

  // Reference instruction: starts in FETCH, returns the phase expected after it ends.
  task automatic instr(input int n_wait, input bit acc, input bit tmo, input int halt_stage,
                       input int drop_at, output int nxt);
    logic latch_b;
    for (int s = 1; s <= 3; s++)
      cyc(s, run_at(s, drop_at), 1'b0, 1'b0, logic'(s == halt_stage));
    if (!acc) begin
      cyc(4, run_at(4, drop_at), 1'b0, logic'($urandom_range(0, 1)), logic'(halt_stage == 4));
    end else if (tmo) begin
      for (int k = 0; k < MEM_TIMEOUT; k++)
        cyc(4, run_at(4, drop_at), 1'b1, 1'b0, logic'(halt_stage == 4 && k == 0));
      exp_err = 1'b1;
      nxt = 6;
      return;
    end else begin
      for (int k = 0; k <= n_wait; k++)
        cyc(4, run_at(4, drop_at), 1'b1, logic'(k == n_wait),
            logic'(halt_stage == 4 && k == n_wait));
    end
    latch_b = exp_latch;
    cyc(5, run_at(5, drop_at), 1'b0, 1'b0, logic'(halt_stage == 5));
    exp_retired = exp_retired + 64'd1;
    nxt = latch_b ? 6 : (run_at(5, drop_at) ? 1 : 0);
  endtask

  initial begin
    int nxt;
    int nw;
    int drop;
    bit acc;
    reset = 1'b1; run = 1'b0; mem_access = 1'b0; mem_ready = 1'b0; halt_req = 1'b0;
    exp_retired = '0; exp_err = 1'b0; exp_latch = 1'b0;

    // Three back-to-back register-only instructions.
    do_reset();
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) instr(0, 1'b0, 1'b0, 0, 6, nxt);
    chk("three_retired", retired, 64'd3);

    // Memory wait of 3 cycles, then ready.
    do_reset();
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b0);
    instr(3, 1'b1, 1'b0, 0, 6, nxt);
    cyc(nxt, 1'b0, 1'b0, 1'b0, 1'b0);

    // Memory timeout: HALTED with sticky error, no retirement, stays halted.
    do_reset();
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b0);
    instr(0, 1'b1, 1'b0, 0, 6, nxt);
    instr(0, 1'b1, 1'b1, 0, 6, nxt);
    for (int i = 0; i < 3; i++) cyc(nxt, 1'b1, 1'b1, 1'b1, 1'b0);

    // Instruction limit on the second instance.
    do_reset();
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      instr(i, 1'b1, 1'b0, 0, 6, nxt);
      chk("lim_retired", l_retired, exp_retired);
      chk("lim_halted", l_halted, 64'(i == 3));
    end
    chk("lim_phase", 64'(l_phase), 64'(PH_HALTED));
    instr(0, 1'b0, 1'b0, 0, 6, nxt);
    chk("lim_retired_hold", l_retired, 64'd4);
    chk("lim_halted_hold", l_halted, 64'd1);
    chk("lim_pc_we_quiet", l_pc_we, 64'd0);

    // Halt pulsed in DECODE, then reset out of HALTED.
    do_reset();
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b0);
    instr(0, 1'b0, 1'b0, 2, 6, nxt);
    for (int i = 0; i < 2; i++) cyc(nxt, 1'b1, 1'b0, 1'b0, 1'b0);
    do_reset();

    // Halt together with mem_ready in the same MEMORY cycle.
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b0);
    instr(2, 1'b1, 1'b0, 4, 6, nxt);
    cyc(nxt, 1'b1, 1'b0, 1'b0, 1'b0);

    // Halt during WRITEBACK stops after the following instruction.
    do_reset();
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b0);
    instr(0, 1'b0, 1'b0, 5, 6, nxt);
    instr(1, 1'b1, 1'b0, 0, 6, nxt);
    cyc(nxt, 1'b1, 1'b0, 1'b0, 1'b0);

    // Halt in IDLE goes straight to HALTED.
    do_reset();
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(6, 1'b1, 1'b0, 1'b0, 1'b0);

    // run dropped in EXECUTE: instruction completes, then IDLE.
    do_reset();
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b0);
    instr(0, 1'b0, 1'b0, 0, 3, nxt);
    for (int i = 0; i < 2; i++) cyc(nxt, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a MEMORY wait.
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b0);
    instr(0, 1'b0, 1'b0, 0, 6, nxt);
    for (int s = 1; s <= 3; s++) cyc(s, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(4, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(4, 1'b1, 1'b1, 1'b0, 1'b0);
    do_reset();

    // Randomized instruction stream against the reference model.
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b0);
    nxt = 1;
    for (int i = 0; i < 40; i++) begin
      if (nxt == 0) cyc(0, 1'b1, 1'b0, 1'b0, 1'b0);
      acc  = bit'($urandom_range(0, 1));
      nw   = int'($urandom_range(0, MEM_TIMEOUT - 1));
      drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 5)) : 6;
      instr(nw, acc, 1'b0, 0, drop, nxt);
    end
    if (nxt == 0) cyc(0, 1'b1, 1'b0, 1'b0, 1'b0);
    instr(int'($urandom_range(0, 5)), 1'b1, 1'b0, int'($urandom_range(1, 4)), 6, nxt);
    cyc(nxt, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Single-clock control FSM that replaces the free-running oscillator-plus-delay phase clocks in the non-pipelined LEGv8 core. It walks each instruction through fetch, decode, execute, memory and writeback, and drives one-cycle enables into the Fetch, Decode, Memory and Writeback stages. It waits on a memory ready handshake, counts retired instructions, and stops the core on a halt request, an instruction limit, or a memory timeout.

## Interface
- `MAX_INSTR`, default 0: instruction limit; the core halts after this many retirements; 0 = unlimited.
- `MEM_TIMEOUT`, default 15: maximum cycles spent in MEMORY waiting for `mem_ready` (≥1).
- `clk` in 1: single system clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `run` in 1: start/continue execution; level-sensitive.
- `mem_access` in 1: `mem_read | mem_write` from Decode; sampled in MEMORY.
- `mem_ready` in 1: Memory stage has completed the access this cycle.
- `halt_req` in 1: request to stop after the current instruction.
- `pc_we` out 1: PC update strobe to Fetch (writes `branch_target` or PC+4 per `pc_src`).
- `instr_mem_en` out 1: instruction memory read enable.
- `reg_read_en` out 1: register file read enable.
- `mem_en` out 1: data memory enable; gates `mem_read`/`mem_write`.
- `reg_write_en` out 1: register file write strobe; gated externally with `reg_write`.
- `phase` out 3: current state encoding.
- `busy` out 1: state is neither IDLE nor HALTED.
- `halted` out 1: state is HALTED.
- `mem_error` out 1: sticky; set when a memory timeout occurred.
- `retired` out `WORD`: count of completed instructions.

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALTED=6.
- Moore outputs, decoded from the state register:
  - FETCH drives `instr_mem_en`.
  - DECODE drives `reg_read_en`.
  - MEMORY drives `mem_en` when `mem_access`=1.
  - WRITEBACK drives `reg_write_en` and `pc_we`.
  - All other enables are 0.
- IDLE→FETCH when `run`=1; otherwise stay in IDLE.
- FETCH→DECODE→EXECUTE→MEMORY, one cycle each, unconditionally.
- MEMORY:
  - If `mem_access`=0 or `mem_ready`=1, go to WRITEBACK.
  - Otherwise increment the wait counter.
  - If the counter equals `MEM_TIMEOUT` with `mem_ready`=0, go to HALTED and set `mem_error`. No writeback and no `retired` increment.
- WRITEBACK:
  - `retired` increments.
  - Go to HALTED if the halt latch is set, or if `MAX_INSTR`≠0 and `retired`+1==`MAX_INSTR`.
  - Otherwise go to FETCH if `run`=1, else IDLE.
- `halt_req` is latched in any busy state, and in the cycle WRITEBACK is entered. The latch clears only on reset. In IDLE, `halt_req`=1 goes directly to HALTED.
- HALTED is absorbing; only `reset` leaves it.
- Deasserting `run` mid-instruction does not abort; the instruction completes through WRITEBACK.
- Wait counter width is `$clog2(MEM_TIMEOUT+1)`. It clears on entry to MEMORY.
- `retired` wraps modulo 2^`WORD`.

## Timing
- Reset values: state IDLE, `phase`=0, all enables 0, `busy`=0, `halted`=0, `mem_error`=0, `retired`=0, halt latch 0, wait counter 0.
- Reset asserted in any state takes effect at the next edge and overrides every other transition, including HALTED.
- Instruction latency:
  - 5 cycles with no memory access, or with `mem_ready` already high in the first MEMORY cycle.
  - 5+N cycles when `mem_ready` rises after N wait cycles, for N<`MEM_TIMEOUT`.
- Back-to-back instructions with `run` held high: WRITEBACK is followed immediately by FETCH; each enable pulses once every 5 cycles.
- `halt_req` and `mem_ready` in the same MEMORY cycle: the access completes, WRITEBACK runs, then HALTED.

## Structure
- Shared package `sequencer_pkg`: `phase_t` enum with the encodings above, plus the `WORD` width constant (aligned with `constants.vh`).
- No sub-module is needed; only the state register, wait counter and retire counter.
- `datapath` instantiates `stage_sequencer` in place of the delay chain. Stage clocks become `clk` qualified by the matching enable.

## Test plan
- Reset, then `run`=1, `mem_access`=0 for 3 instructions → `pc_we` pulses at cycles 5, 10, 15 after run; `retired`=3; `phase` sequence 1,2,3,4,5 repeating.
- `mem_access`=1, `mem_ready` low for 3 cycles then high → MEMORY lasts 4 cycles; instruction latency 8; `mem_en` high for all 4.
- `mem_access`=1, `mem_ready` held 0, `MEM_TIMEOUT`=15 → HALTED after 15 MEMORY cycles; `mem_error`=1; `retired` unchanged; `reg_write_en` never asserts.
- `MAX_INSTR`=4 → `halted`=1 the cycle after the 4th WRITEBACK; `retired`=4; `run` held high has no further effect.
- `halt_req` pulsed for one cycle during DECODE → current instruction retires, then HALTED; `reset` in HALTED → IDLE with all outputs 0.
- `run` dropped during EXECUTE → instruction completes, then IDLE with `busy`=0; `reset` asserted in the middle of MEMORY → IDLE next edge, `retired`=0.
